// File: rtl/sd_cmd_seq_pkg.sv
// rtl/sd_cmd_seq_pkg.sv - states, spi register map and frame helper for sd_cmd_seq
package sd_cmd_pkg;

  typedef enum logic [3:0] {
    S_PWRUP,
    S_IDLE,
    S_CS_LO,
    S_PRE,
    S_FRAME,
    S_POLL,
    S_EXT,
    S_CS_HI,
    S_POST,
    S_FIN
  } seq_state_t;

  localparam logic [2:0] SPI_ADDR_DATA  = 3'd0;
  localparam logic [2:0] SPI_ADDR_FF    = 3'd1;
  localparam logic [2:0] SPI_ADDR_CS_HI = 3'd3;
  localparam logic [2:0] SPI_ADDR_CS_LO = 3'd4;

  localparam logic [1:0] FRAME_START = 2'b01;

  // Byte idx of the 6-byte command frame: start+index, argument MSB first, CRC7 + end bit.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [5:0] cmd,
                                            input logic [31:0] arg, input logic [6:0] crc);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {FRAME_START, cmd};
      3'd1:    b = arg[31:24];
      3'd2:    b = arg[23:16];
      3'd3:    b = arg[15:8];
      3'd4:    b = arg[7:0];
      3'd5:    b = {crc, 1'b1};
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sd_cmd_seq_if.sv
// rtl/sd_cmd_seq_if.sv - write/read port between the sequencer and the byte-level spi master
interface sd_cmd_seq_if;
  logic       spi_en;
  logic       spi_rnw;
  logic [2:0] spi_addr;
  logic [7:0] spi_din;
  logic [7:0] spi_dout;

  modport master (output spi_en, output spi_rnw, output spi_addr, output spi_din, input spi_dout);
  modport slave  (input spi_en, input spi_rnw, input spi_addr, input spi_din, output spi_dout);
endinterface

// File: rtl/sd_cmd_seq_spi_byte_timer.sv
// rtl/sd_cmd_seq_spi_byte_timer.sv - loadable down-counter pacing spi bytes and the power-up wait
module spi_byte_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  // Count down from the loaded value and park at zero until the next load.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/sd_cmd_seq.sv
// rtl/sd_cmd_seq.sv - SD SPI-mode command sequencer; SD_CMD_SEQ_EXT_RESP_EN adds R3/R7 capture
module sd_cmd_seq
  import sd_cmd_pkg::*;
#(
  parameter int POWERUP_CYCLES = 22600,
  parameter int BYTE_WAIT      = 18,
  parameter int NCR_MAX        = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [5:0]   cmd,
  input  logic [31:0]  arg,
  input  logic [6:0]   crc,
  input  logic         long_resp,
  output logic         busy,
  output logic         done,
  output logic [7:0]   r1,
  output logic         timeout,
  output logic [31:0]  resp_ext,
  sd_cmd_seq_if.master spi
);

  localparam int TW = $clog2(POWERUP_CYCLES + BYTE_WAIT + 1);

  seq_state_t    state_q, state_d;
  logic          in_wait_q, in_wait_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    poll_q, poll_d, poll_inc;
  logic [5:0]    cmd_q, cmd_d;
  logic [31:0]   arg_q, arg_d;
  logic [6:0]    crc_q, crc_d;
  logic [7:0]    r1_q, r1_d;
  logic          to_q, to_d;
  logic          done_q, done_d;
  logic          tmr_load, tmr_expired, step;
  logic [TW-1:0] tmr_val;
  logic          byte_state;
  logic [2:0]    byte_addr;
  logic [7:0]    byte_din;
`ifdef SD_CMD_SEQ_EXT_RESP_EN
  logic          long_q, long_d;
  logic [31:0]   ext_q, ext_d;
`else
  logic          unused_long;
  assign unused_long = long_resp;
`endif

  spi_byte_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  assign step     = in_wait_q & tmr_expired;
  assign poll_inc = poll_q + 4'd1;

  // Register FSM state, byte/poll counters and the latched request/response fields.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_PWRUP;
      in_wait_q <= 1'b0;
      idx_q     <= '0;
      poll_q    <= '0;
      cmd_q     <= '0;
      arg_q     <= '0;
      crc_q     <= '0;
      r1_q      <= 8'hFF;
      to_q      <= 1'b0;
      done_q    <= 1'b0;
`ifdef SD_CMD_SEQ_EXT_RESP_EN
      long_q    <= 1'b0;
      ext_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      in_wait_q <= in_wait_d;
      idx_q     <= idx_d;
      poll_q    <= poll_d;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
      crc_q     <= crc_d;
      r1_q      <= r1_d;
      to_q      <= to_d;
      done_q    <= done_d;
`ifdef SD_CMD_SEQ_EXT_RESP_EN
      long_q    <= long_d;
      ext_q     <= ext_d;
`endif
    end
  end

  // Next state, spi strobes and timer loads; waited bytes strobe once, then wait for expiry.
  always_comb begin
    state_d    = state_q;
    in_wait_d  = in_wait_q;
    idx_d      = idx_q;
    poll_d     = poll_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    crc_d      = crc_q;
    r1_d       = r1_q;
    to_d       = to_q;
    done_d     = (state_q == S_FIN);
    tmr_load   = 1'b0;
    tmr_val    = TW'(BYTE_WAIT - 1);
    byte_state = 1'b0;
    byte_addr  = SPI_ADDR_FF;
    byte_din   = 8'hFF;
    spi.spi_en   = 1'b0;
    spi.spi_rnw  = 1'b1;
    spi.spi_addr = '0;
    spi.spi_din  = 8'hFF;
`ifdef SD_CMD_SEQ_EXT_RESP_EN
    long_d = long_q;
    ext_d  = ext_q;
`endif
    case (state_q)
      S_PWRUP: begin
        if (!in_wait_q) begin
          tmr_load  = 1'b1;
          tmr_val   = TW'(POWERUP_CYCLES - 2);
          in_wait_d = 1'b1;
        end else if (tmr_expired) begin
          in_wait_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_IDLE: begin
        if (start) begin
          cmd_d     = cmd;
          arg_d     = arg;
          crc_d     = crc;
          r1_d      = 8'hFF;
          to_d      = 1'b0;
          poll_d    = '0;
          idx_d     = '0;
          in_wait_d = 1'b0;
          state_d   = S_CS_LO;
`ifdef SD_CMD_SEQ_EXT_RESP_EN
          long_d = long_resp;
          ext_d  = '0;
`endif
        end
      end
      S_CS_LO: begin
        spi.spi_en   = 1'b1;
        spi.spi_rnw  = 1'b0;
        spi.spi_addr = SPI_ADDR_CS_LO;
        state_d      = S_PRE;
      end
      S_PRE: begin
        byte_state = 1'b1;
        if (step) begin
          in_wait_d = 1'b0;
          idx_d     = '0;
          state_d   = S_FRAME;
        end
      end
      S_FRAME: begin
        byte_state = 1'b1;
        byte_addr  = SPI_ADDR_DATA;
        byte_din   = frame_byte(idx_q, cmd_q, arg_q, crc_q);
        if (step) begin
          in_wait_d = 1'b0;
          if (idx_q == 3'd5) begin
            idx_d   = '0;
            state_d = S_POLL;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_POLL: begin
        byte_state = 1'b1;
        if (step) begin
          in_wait_d = 1'b0;
          if (!spi.spi_dout[7]) begin
            r1_d = spi.spi_dout;
`ifdef SD_CMD_SEQ_EXT_RESP_EN
            state_d = long_q ? S_EXT : S_CS_HI;
`else
            state_d = S_CS_HI;
`endif
          end else begin
            poll_d = poll_inc;
            if (poll_inc == 4'(NCR_MAX)) begin
              to_d    = 1'b1;
              state_d = S_CS_HI;
            end
          end
        end
      end
`ifdef SD_CMD_SEQ_EXT_RESP_EN
      S_EXT: begin
        byte_state = 1'b1;
        if (step) begin
          in_wait_d = 1'b0;
          ext_d     = {ext_q[23:0], spi.spi_dout};
          if (idx_q == 3'd3) begin
            idx_d   = '0;
            state_d = S_CS_HI;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`endif
      S_CS_HI: begin
        spi.spi_en   = 1'b1;
        spi.spi_rnw  = 1'b0;
        spi.spi_addr = SPI_ADDR_CS_HI;
        state_d      = S_POST;
      end
      S_POST: begin
        byte_state = 1'b1;
        if (step) begin
          in_wait_d = 1'b0;
          state_d   = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_PWRUP;
        in_wait_d = 1'b0;
      end
    endcase
    if (byte_state && !in_wait_q) begin
      spi.spi_en   = 1'b1;
      spi.spi_rnw  = 1'b0;
      spi.spi_addr = byte_addr;
      spi.spi_din  = byte_din;
      tmr_load     = 1'b1;
      in_wait_d    = 1'b1;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign r1      = r1_q;
  assign timeout = to_q;
`ifdef SD_CMD_SEQ_EXT_RESP_EN
  assign resp_ext = ext_q;
`else
  assign resp_ext = '0;
`endif

endmodule

// File: tb/tb_sd_cmd_seq.sv
// tb/tb_sd_cmd_seq.sv - self-checking bench for sd_cmd_seq with a scheduled-transaction model
module tb_sd_cmd_seq;

  localparam int P    = 300;
  localparam int BW   = 18;
  localparam int NCR  = 8;
  localparam int SLOT = BW + 1;

  typedef struct {
    int         c;
    logic [2:0] a;
    logic [7:0] d;
    logic       rnw;
  } strobe_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cmd = '0;
  logic [31:0] arg = '0;
  logic [6:0]  crc = '0;
  logic        long_resp = 1'b0;
  logic        busy, done, timeout;
  logic [7:0]  r1;
  logic [31:0] resp_ext;

  sd_cmd_seq_if spi_bus ();

  sd_cmd_seq #(.POWERUP_CYCLES(P), .BYTE_WAIT(BW), .NCR_MAX(NCR)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .cmd       (cmd),
    .arg       (arg),
    .crc       (crc),
    .long_resp (long_resp),
    .busy      (busy),
    .done      (done),
    .r1        (r1),
    .timeout   (timeout),
    .resp_ext  (resp_ext),
    .spi       (spi_bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  strobe_t obs_q[$];
  strobe_t exp_q[$];
  int done_q[$];
  logic [7:0] card_q[$];
  int n_data = 0;
  bit past_cs_hi = 1'b0;
  logic [7:0]  exp_r1;
  logic        exp_to;
  logic [31:0] exp_ext;
  int exp_done;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe strobes/done away from the edge and act as the SD card behind the spi master.
  always @(negedge clk) begin
    if (done) done_q.push_back(cyc);
    if (spi_bus.spi_en) begin
      obs_q.push_back('{cyc, spi_bus.spi_addr, spi_bus.spi_din, spi_bus.spi_rnw});
      case (spi_bus.spi_addr)
        3'd4: begin n_data = 0; past_cs_hi = 1'b0; end
        3'd0: n_data++;
        3'd3: past_cs_hi = 1'b1;
        3'd1: begin
          if (n_data == 6 && !past_cs_hi && card_q.size() > 0) spi_bus.spi_dout = card_q.pop_front();
          else spi_bus.spi_dout = 8'hFF;
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pack(input strobe_t s);
    logic [7:0] d;
    d = (s.a == 3'd0 || s.a == 3'd1) ? s.d : 8'h00;
    return {s.c, 5'b0, s.a, d, 7'b0, s.rnw, 8'h00};
  endfunction

  task automatic push_exp(input int c, input logic [2:0] a, input logic [7:0] d);
    strobe_t s;
    s.c = c; s.a = a; s.d = d; s.rnw = 1'b0;
    exp_q.push_back(s);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_strobes(input string tag, input int k);
    int lim;
    lim = cyc + 2000;
    while (obs_q.size() < k && cyc < lim) @(negedge clk);
    check(tag, 64'(obs_q.size() >= k), 64'd1);
  endtask

  // Card answers npre busy bytes (bit7 set) then r1v and four extended bytes.
  task automatic begin_txn(input logic [5:0] c, input logic [31:0] a, input logic [6:0] k,
                           input logic l, input int npre, input logic [7:0] r1v,
                           input logic [31:0] ext);
    int m, npoll, next_b, acc;
    logic to;
    logic [7:0] fb [6];
    card_q.delete(); obs_q.delete(); exp_q.delete(); done_q.delete();
    for (int i = 0; i < npre; i++) card_q.push_back(8'h80 | 8'($urandom_range(0, 127)));
    if (npre < NCR) begin
      card_q.push_back(r1v);
      for (int i = 0; i < 4; i++) card_q.push_back(ext[31 - 8*i -: 8]);
    end
    to     = (npre >= NCR);
    npoll  = to ? NCR : npre + 1;
    exp_r1 = to ? 8'hFF : r1v;
    exp_to = to;
`ifdef SD_CMD_SEQ_EXT_RESP_EN
    next_b  = (l && !to) ? 4 : 0;
    exp_ext = (next_b != 0) ? ext : 32'h0;
`else
    next_b  = 0;
    exp_ext = 32'h0;
`endif
    fb[0] = {2'b01, c};
    fb[1] = a[31:24];
    fb[2] = a[23:16];
    fb[3] = a[15:8];
    fb[4] = a[7:0];
    fb[5] = {k, 1'b1};
    @(posedge clk); #1;
    cmd = c; arg = a; crc = k; long_resp = l; start = 1'b1;
    acc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    cmd = 6'($urandom); arg = $urandom; crc = 7'($urandom); long_resp = 1'($urandom);
    push_exp(acc + 1, 3'd4, 8'h00);
    m = 0;
    push_exp(acc + 2 + SLOT*m, 3'd1, 8'hFF); m++;
    for (int i = 0; i < 6; i++) begin push_exp(acc + 2 + SLOT*m, 3'd0, fb[i]); m++; end
    for (int i = 0; i < npoll + next_b; i++) begin push_exp(acc + 2 + SLOT*m, 3'd1, 8'hFF); m++; end
    push_exp(acc + 2 + SLOT*m, 3'd3, 8'h00);
    push_exp(acc + 3 + SLOT*m, 3'd1, 8'hFF);
    exp_done = acc + 3 + SLOT*m + SLOT + 1;
  endtask

  task automatic finish_txn(input string tag);
    int lim, n;
    lim = exp_done + 40;
    while (done_q.size() == 0 && cyc < lim) @(negedge clk);
    check({tag, "/done_seen"}, 64'(done_q.size() != 0), 64'd1);
    if (done_q.size() != 0) check({tag, "/done_cycle"}, 64'(done_q[0]), 64'(exp_done));
    repeat (4) @(negedge clk);
    check({tag, "/done_pulses"}, 64'(done_q.size()), 64'd1);
    check({tag, "/busy"}, 64'(busy), 64'd0);
    check({tag, "/r1"}, 64'(r1), 64'(exp_r1));
    check({tag, "/timeout"}, 64'(timeout), 64'(exp_to));
    check({tag, "/resp_ext"}, 64'(resp_ext), 64'(exp_ext));
    check({tag, "/n_strobes"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s/strobe%0d", tag, i), pack(obs_q[i]), pack(exp_q[i]));
  endtask

  initial begin
    int rel, n;
    spi_bus.spi_dout = 8'hFF;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/busy", 64'(busy), 64'd1);
    check("rst/done", 64'(done), 64'd0);
    check("rst/r1", 64'(r1), 64'hFF);
    check("rst/timeout", 64'(timeout), 64'd0);
    check("rst/resp_ext", 64'(resp_ext), 64'd0);
    check("rst/spi_en", 64'(spi_bus.spi_en), 64'd0);
    check("rst/spi_rnw", 64'(spi_bus.spi_rnw), 64'd1);
    check("rst/spi_addr", 64'(spi_bus.spi_addr), 64'd0);
    check("rst/spi_din", 64'(spi_bus.spi_din), 64'hFF);

    // Power-up: a start during the wait is dropped; busy falls at POWERUP_CYCLES.
    @(posedge clk); #1;
    reset_n = 1'b1;
    rel = cyc;
    obs_q.delete(); done_q.delete();
    wait_cyc(rel + 100);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cyc(rel + P - 1);
    @(negedge clk);
    check("pwr/busy_before", 64'(busy), 64'd1);
    wait_cyc(rel + P);
    @(negedge clk);
    check("pwr/busy_after", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("pwr/no_strobes", 64'(obs_q.size()), 64'd0);
    check("pwr/no_done", 64'(done_q.size()), 64'd0);

    // CMD0 with two busy bytes before R1.
    begin_txn(6'd0, 32'h0, 7'h4A, 1'b0, 2, 8'h01, 32'h0);
    finish_txn("cmd0");

    // CMD8 with long response.
    begin_txn(6'd8, 32'h0000_01AA, 7'h43, 1'b1, 0, 8'h01, 32'h0000_01AA);
    finish_txn("cmd8");

    // Timeout: card never answers.
    begin_txn(6'd55, $urandom, 7'($urandom), 1'b1, NCR, 8'h00, $urandom);
    finish_txn("timeout");

    // R1 on the very last permitted poll.
    begin_txn(6'd17, $urandom, 7'($urandom), 1'b0, NCR - 1, 8'h05, $urandom);
    finish_txn("last_poll");

    // Randomized transactions.
    for (int t = 0; t < 12; t++) begin
      begin_txn(6'($urandom), $urandom, 7'($urandom), 1'($urandom), $urandom_range(0, NCR),
                {1'b0, 7'($urandom)}, $urandom);
      finish_txn($sformatf("rand%0d", t));
    end

    // A start mid-FRAME is dropped and does not disturb the latched argument.
    begin_txn(6'd24, 32'hDEAD_BEEF, 7'h11, 1'b0, 1, 8'h00, 32'h0);
    wait_strobes("drop/reach_frame", 5);
    @(posedge clk); #1;
    cmd = 6'd63; arg = 32'h1234_5678; crc = 7'h7F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_txn("drop");
    repeat (60) @(negedge clk);
    check("drop/no_second_txn", 64'(obs_q.size()), 64'(exp_q.size()));
    check("drop/single_done", 64'(done_q.size()), 64'd1);

    // Reset during POLL returns to the power-up wait with no further strobes.
    begin_txn(6'd1, $urandom, 7'($urandom), 1'b0, NCR, 8'h00, 32'h0);
    wait_strobes("rstpoll/reach_poll", 10);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    rel = cyc;
    @(negedge clk);
    check("rstpoll/spi_en", 64'(spi_bus.spi_en), 64'd0);
    check("rstpoll/busy", 64'(busy), 64'd1);
    check("rstpoll/r1", 64'(r1), 64'hFF);
    n = obs_q.size();
    done_q.delete();
    wait_cyc(rel + P - 1);
    @(negedge clk);
    check("rstpoll/busy_before", 64'(busy), 64'd1);
    wait_cyc(rel + P);
    @(negedge clk);
    check("rstpoll/busy_after", 64'(busy), 64'd0);
    check("rstpoll/no_strobes", 64'(obs_q.size()), 64'(n));
    check("rstpoll/no_done", 64'(done_q.size()), 64'd0);

    // Recovery after the mid-transaction reset.
    begin_txn(6'($urandom), $urandom, 7'($urandom), 1'($urandom), $urandom_range(0, NCR),
              {1'b0, 7'($urandom)}, $urandom);
    finish_txn("recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
